// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the shift-add multiplier.
// The master drives the request and operands; the slave (multiplier) returns status and result.
interface shift_add_multiplier_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  product,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output product,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N multiplier: one partial product per clock through an
// N-bit ripple-carry adder, fixed N-cycle latency, start/busy/done handshake.
module shift_add_multiplier_rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] carry_s;

    // Ripple the carry bit by bit from c_in up to c_out.
    always_comb begin
        sum        = {N{1'b0}};
        carry_s    = {(N+1){1'b0}};
        carry_s[0] = c_in;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
        end
        c_out = carry_s[N];
    end
endmodule

module shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [N-1:0]       a_r;
    logic [N-1:0]       acc_r;
    logic [N-1:0]       q_r;
    logic [CNT_W-1:0]   count_r;
    logic [2*N-1:0]     product_r;
    logic [N-1:0]       add_sum_s;
    logic               add_cout_s;
    logic [N:0]         part_s;
    logic [2*N-1:0]     shift_s;
    logic               last_iter_s;
    logic               busy_s;
    logic               done_s;

    shift_add_multiplier_rca #(.N(N)) u_adder (
        .a     (acc_r),
        .b     (a_r),
        .c_in  (1'b0),
        .sum   (add_sum_s),
        .c_out (add_cout_s)
    );

    // Select the adder result only when the current multiplier bit is set, then shift right.
    always_comb begin
        if (q_r[0]) begin
            part_s = {add_cout_s, add_sum_s};
        end else begin
            part_s = {1'b0, acc_r};
        end
        shift_s     = {part_s, q_r[N-1:1]};
        last_iter_s = (count_r == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_iter_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Status outputs decoded from the state register, so no path from start.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            CALC: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand, accumulator, counter and product registers; product moves only on the last iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= {N{1'b0}};
            acc_r     <= {N{1'b0}};
            q_r       <= {N{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            product_r <= {(2*N){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.multiplicand;
                        q_r     <= bus.multiplier;
                        acc_r   <= {N{1'b0}};
                        count_r <= CNT_W'(N);
                    end else begin
                        count_r <= count_r;
                    end
                end
                CALC: begin
                    acc_r   <= shift_s[2*N-1:N];
                    q_r     <= shift_s[N-1:0];
                    count_r <= count_r - CNT_W'(1);
                    if (last_iter_s) begin
                        product_r <= shift_s;
                    end else begin
                        product_r <= product_r;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign bus.product = product_r;
    assign bus.busy    = busy_s;
    assign bus.done    = done_s;
endmodule
